team_gpio_wb_ctrl: RTL and testbench
====================================

TEAM_GPIO_WB_CTRL -- requirements
Module: team_gpio_wb_ctrl

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 32, number of controlled pins (legal 1..32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [7:0] SHALL be zero.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-004 wb_clk_i  in  1  sole clock; all state on its rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-007 wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-009 gpio_in  in  NUM_GPIO  pad inputs, asynchronous to wb_clk_i.
REQ-010 gpio_out  out  NUM_GPIO  pad output values; gpio_oeb  out  NUM_GPIO  active-low output enables.
REQ-011 irq  out  1  level interrupt.

Function
REQ-012 Selected when adr_i[31:8]==BASE_ADDR[31:8]; offset = adr_i[7:2].
REQ-013 Register map: 0x00 OUT (RW), 0x04 OE (RW, 1=drive), 0x08 IN (RO), 0x0C IEN (RW), 0x10 RISE (RW), 0x14 FALL (RW), 0x18 STAT (R/W1C).
REQ-014 Bits at index >= NUM_GPIO SHALL read 0 and ignore writes in every register.
REQ-015 Ack: wbs_ack_o SHALL rise the cycle after cyc&stb&!ack are sampled high, last exactly one cycle, then remain low at least one cycle; 1-cycle latency, no wait states.
REQ-016 Write takes effect on the ack edge, per byte lane where sel_i[n]=1; lanes with sel_i[n]=0 SHALL be unchanged.
REQ-017 Reads SHALL present registered data on wbs_dat_o while ack is high; wbs_dat_o SHALL be 0 when ack is low.
REQ-018 Unmapped offsets inside the window SHALL ack, read 0, and ignore writes; addresses outside the window SHALL never ack.
REQ-019 Writes to IN SHALL be acked and ignored.
REQ-020 gpio_out = OUT; gpio_oeb = ~OE; both driven from flops, no combinational path from the bus.
REQ-021 gpio_in SHALL pass through a SYNC_STAGES flop chain; IN reflects the last stage; one further flop (prev) holds the prior value for edge detection.
REQ-022 Rising edge on bit i (prev=0, sync=1) with RISE[i]=1 SHALL set STAT[i]; falling edge with FALL[i]=1 SHALL set STAT[i]; detection is independent of IEN.
REQ-023 Writing 1 to STAT[i] SHALL clear it; writing 0 SHALL have no effect.
REQ-024 Simultaneous edge-set and W1C on the same bit in one cycle: set wins, bit stays 1.
REQ-025 irq = |(STAT & IEN), registered, 1-cycle delay from STAT/IEN change.
REQ-026 Pad-to-STAT latency SHALL be SYNC_STAGES+1 cycles.
REQ-027 Dropping cyc or stb before ack SHALL abort the cycle with no register update and no ack.

Reset
REQ-028 On wb_rst_i high, immediately and without clock: OUT, OE, IEN, RISE, FALL, STAT, ack, irq, wbs_dat_o = 0; gpio_oeb all 1s (all inputs); synchroniser and prev flops = 0.
REQ-029 Reset asserted mid-transaction SHALL drop ack at once and discard the pending write.
REQ-030 After reset release, no edge SHALL be reported until the synchroniser has refilled (pads already high at release produce a rising edge, discarded because STAT starts 0 and RISE=0).

Verification
REQ-031 Write 0x04=0x0000_00FF sel=4'b0001, then 0x00=0xA5A5_A5A5 sel=4'b1111 -> gpio_oeb[7:0]=0, gpio_oeb[31:8]=1s, gpio_out=0xA5A5_A5A5; ack one cycle each.
REQ-032 Write 0x00=0xFFFF_FFFF sel=4'b0100 after OUT=0 -> OUT reads 0x00FF_0000.
REQ-033 RISE=0x1, IEN=0x1; gpio_in[0] 0->1 -> STAT[0]=1 after 3 cycles (SYNC_STAGES=2), irq=1 one cycle later; write STAT=0x1 -> irq=0.
REQ-034 Edge on bit 0 aligned with W1C of STAT[0] -> STAT[0] reads 1.
REQ-035 Read 0x3C and 0x08 with BASE_ADDR window; read 0x3000_0100 -> 0x3C returns 0 with ack; out-of-window address gets no ack within 10 cycles.
REQ-036 Assert wb_rst_i while ack pending on a write to OUT -> ack low same cycle, OUT=0, gpio_oeb all 1s.

Source files
------------

// File: rtl/team_gpio_wb_ctrl.sv
// GPIO controller with a Wishbone classic slave port.
// Registers: OUT, OE, IN (synchronised pads), IEN, RISE, FALL, STAT (W1C).
// Pad inputs cross into wb_clk_i through a SYNC_STAGES flop chain. A further
// "prev" flop supplies the edge detector that sets STAT bits.
//
// Handshake: a request is cyc_i & stb_i & address-hit & !ack_o. It is sampled
// on a rising edge, and ack_o is high for exactly the following cycle. Any
// write lands on that same edge, and read data is valid only while ack_o is
// high. Because of the !ack_o term, ack_o is low for at least one cycle between
// transfers. A master that drops cyc or stb before the edge aborts cleanly.
module team_gpio_wb_ctrl #(
    parameter int          NUM_GPIO    = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    localparam logic [5:0] OFF_OUT  = 6'h00;
    localparam logic [5:0] OFF_OE   = 6'h01;
    localparam logic [5:0] OFF_IN   = 6'h02;
    localparam logic [5:0] OFF_IEN  = 6'h03;
    localparam logic [5:0] OFF_RISE = 6'h04;
    localparam logic [5:0] OFF_FALL = 6'h05;
    localparam logic [5:0] OFF_STAT = 6'h06;

    logic [NUM_GPIO-1:0] out_q, out_d;
    logic [NUM_GPIO-1:0] oe_q, oe_d;
    logic [NUM_GPIO-1:0] ien_q, ien_d;
    logic [NUM_GPIO-1:0] rise_q, rise_d;
    logic [NUM_GPIO-1:0] fall_q, fall_d;
    logic [NUM_GPIO-1:0] stat_q, stat_d;
    logic [NUM_GPIO-1:0] prev_q;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                irq_q, irq_d;

    logic                hit, req, wr, rd;
    logic [5:0]          offset;
    logic [31:0]         wmask;
    logic [31:0]         rdata;
    logic [31:0]         clr32;
    logic [NUM_GPIO-1:0] stat_clr;
    logic [NUM_GPIO-1:0] sync_last;
    logic [NUM_GPIO-1:0] edge_ev;
    logic                unused_adr_lsb;

    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req       = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign offset    = wbs_adr_i[7:2];
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign sync_last = sync_q[SYNC_STAGES-1];

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [NUM_GPIO-1:0] merge(input logic [NUM_GPIO-1:0] old,
                                                  input logic [31:0] data,
                                                  input logic [31:0] mask);
        logic [31:0] m;
        m = (32'(old) & ~mask) | (data & mask);
        return m[NUM_GPIO-1:0];
    endfunction

    // Next-state for the register file, edge detection, read mux and bus response.
    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        ien_d    = ien_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        clr32    = '0;
        rdata    = '0;
        if (wr) begin
            case (offset)
                OFF_OUT:  out_d  = merge(out_q, wbs_dat_i, wmask);
                OFF_OE:   oe_d   = merge(oe_q, wbs_dat_i, wmask);
                OFF_IEN:  ien_d  = merge(ien_q, wbs_dat_i, wmask);
                OFF_RISE: rise_d = merge(rise_q, wbs_dat_i, wmask);
                OFF_FALL: fall_d = merge(fall_q, wbs_dat_i, wmask);
                OFF_STAT: clr32  = wbs_dat_i & wmask;
                default:  clr32  = '0;
            endcase
        end
        stat_clr = clr32[NUM_GPIO-1:0];
        edge_ev  = (sync_last & ~prev_q & rise_q) | (~sync_last & prev_q & fall_q);
        // A new edge in the same cycle as a clear leaves the bit set.
        stat_d   = (stat_q & ~stat_clr) | edge_ev;
        case (offset)
            OFF_OUT:  rdata = 32'(out_q);
            OFF_OE:   rdata = 32'(oe_q);
            OFF_IN:   rdata = 32'(sync_last);
            OFF_IEN:  rdata = 32'(ien_q);
            OFF_RISE: rdata = 32'(rise_q);
            OFF_FALL: rdata = 32'(fall_q);
            OFF_STAT: rdata = 32'(stat_q);
            default:  rdata = '0;
        endcase
        ack_d = req;
        dat_d = rd ? rdata : '0;
        irq_d = |(stat_q & ien_q);
    end

    // Register file, bus response and interrupt flops.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q  <= '0;
            oe_q   <= '0;
            ien_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            ien_q  <= ien_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    // Pad synchroniser chain plus the prior-value flop for edge detection.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_last;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = out_q;
    assign gpio_oeb  = ~oe_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_team_gpio_wb_ctrl.sv
// Directed bench for team_gpio_wb_ctrl (default parameters).
module tb_team_gpio_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] gin, gout, goeb;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    team_gpio_wb_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .gpio_in  (gin),
        .gpio_out (gout),
        .gpio_oeb (goeb),
        .irq      (irq)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One classic single transfer; checks 1-cycle ack and its one-cycle width.
    task automatic wb_cycle(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] r);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_drop"}, {31'd0, ack}, 32'd0);
        check({tag, "_dat_idle"}, rdat, 32'd0);
    endtask

    task automatic wb_write(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_cycle(tag, 1'b1, a, d, s, r);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] r;
        logic [31:0] exp_v;
        exp_q.push_back(e);
        wb_cycle(tag, 1'b0, a, 32'd0, 4'hF, r);
        exp_v = exp_q.pop_front();
        check({tag, "_data"}, r, exp_v);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        logic seen;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0; gin = '0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_out", gout, 32'd0);
        check("rst_oeb", goeb, 32'hFFFF_FFFF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Output enable on the low lane only, then full OUT write.
        wb_write("w_oe", BASE + 32'h04, 32'h0000_00FF, 4'b0001);
        wb_write("w_out", BASE + 32'h00, 32'hA5A5_A5A5, 4'b1111);
        check("oeb_val", goeb, 32'hFFFF_FF00);
        check("out_val", gout, 32'hA5A5_A5A5);
        wb_read("r_oe", BASE + 32'h04, 32'h0000_00FF);
        wb_read("r_out", BASE + 32'h00, 32'hA5A5_A5A5);

        // Single byte lane write.
        wb_write("w_out0", BASE + 32'h00, 32'h0000_0000, 4'b1111);
        wb_write("w_lane2", BASE + 32'h00, 32'hFFFF_FFFF, 4'b0100);
        wb_read("r_lane2", BASE + 32'h00, 32'h00FF_0000);

        // IN register through the synchroniser.
        gin = 32'h1234_5678;
        wait_cycles(4);
        wb_read("r_in", BASE + 32'h08, 32'h1234_5678);
        gin = 32'h0;
        wait_cycles(4);
        wb_read("r_stat0", BASE + 32'h18, 32'h0);

        // Rising edge on bit 0: STAT after 3 cycles, irq one later.
        wb_write("w_rise", BASE + 32'h10, 32'h1, 4'hF);
        wb_write("w_ien", BASE + 32'h0C, 32'h1, 4'hF);
        @(negedge clk); gin = 32'h1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("irq_early", {31'd0, irq}, 32'd0);
        end
        @(posedge clk); #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        wb_read("r_stat1", BASE + 32'h18, 32'h1);
        wb_write("w_stat_zero", BASE + 32'h18, 32'h0, 4'hF);
        wb_read("r_stat_keep", BASE + 32'h18, 32'h1);
        wb_write("w_stat_clr", BASE + 32'h18, 32'h1, 4'hF);
        check("irq_clr", {31'd0, irq}, 32'd0);
        wb_read("r_stat_clr", BASE + 32'h18, 32'h0);

        // Edge set coincides with W1C: set wins.
        @(negedge clk); gin = 32'h0;
        wait_cycles(4);
        @(negedge clk); gin = 32'h1;
        repeat (2) @(posedge clk);
        wb_write("w_stat_race", BASE + 32'h18, 32'h1, 4'hF);
        wb_read("r_stat_race", BASE + 32'h18, 32'h1);
        check("irq_race", {31'd0, irq}, 32'd1);
        wb_write("w_stat_clr2", BASE + 32'h18, 32'h1, 4'hF);

        // Falling edge detection.
        wb_write("w_fall", BASE + 32'h14, 32'h1, 4'hF);
        @(negedge clk); gin = 32'h0;
        wait_cycles(4);
        wb_read("r_stat_fall", BASE + 32'h18, 32'h1);
        wb_write("w_stat_clr3", BASE + 32'h18, 32'h1, 4'hF);
        wb_read("r_stat_clr3", BASE + 32'h18, 32'h0);

        // Window, unmapped offsets, read-only IN.
        @(negedge clk); gin = 32'hCAFE_0000;
        wait_cycles(4);
        wb_read("r_3c", BASE + 32'h3C, 32'h0);
        wb_read("r_in2", BASE + 32'h08, 32'hCAFE_0000);
        wb_write("w_in", BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
        wb_read("r_in3", BASE + 32'h08, 32'hCAFE_0000);
        wb_write("w_unmapped", BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        wb_read("r_unmapped", BASE + 32'h20, 32'h0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100;
        wdat = 32'h1111_1111; sel = 4'hF;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("oow_noack", {31'd0, seen}, 32'd0);
        wb_read("r_out_oow", BASE + 32'h00, 32'h00FF_0000);

        // Abort: stb dropped before the sampling edge.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("abort_noack", {31'd0, ack}, 32'd0);
        wb_read("r_out_abort", BASE + 32'h00, 32'h00FF_0000);

        // Reset while ack is high on a write to OUT; pads high through release.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'd0, ack}, 32'd1);
        rst = 1'b1; gin = 32'hFFFF_FFFF;
        #1;
        check("mid_rst_ack", {31'd0, ack}, 32'd0);
        check("mid_rst_out", gout, 32'd0);
        check("mid_rst_oeb", goeb, 32'hFFFF_FFFF);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); rst = 1'b0;
        wait_cycles(5);
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        wb_read("r_out_rst", BASE + 32'h00, 32'h0);
        wb_write("w_rise_all", BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        wb_write("w_ien_all", BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        wb_read("r_stat_rst", BASE + 32'h18, 32'h0);
        check("post_rst_irq2", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
